// File: rtl/bp_pkg.sv
// bp_pkg: shared constants, arbiter-state enum and counter arithmetic for bp_table_ctrl.
//   SNT/WNT/WT/ST  2-bit counter states
//   CNT_RST        counter reset value
//   arb_state_t    table-port arbiter states
//   sat_upd()      saturating counter update
package bp_pkg;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;
    localparam logic [1:0] CNT_RST = ST;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        DRAIN  = 2'd2
    } arb_state_t;

    function automatic logic [1:0] sat_upd(input logic [1:0] c, input logic taken);
        return taken ? ((c == ST) ? ST : c + 2'd1) : ((c == SNT) ? SNT : c - 2'd1);
    endfunction

endpackage

// File: rtl/bp_update_fifo.sv
// bp_update_fifo: DEPTH-entry queue of pending {idx, taken} counter updates.
//   clk, rst_n  clock, asynchronous active-low reset (empties the queue)
//   push, din   write an entry (caller guarantees not full)
//   pop, dout   head entry, removed on pop (caller guarantees not empty)
//   full, empty occupancy flags
module bp_update_fifo
    import bp_pkg::*;
#(
    parameter int W     = 5,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign full  = cnt == (AW+1)'(DEPTH);
    assign empty = cnt == '0;

endmodule

// File: rtl/bp_table_ctrl.sv
// bp_table_ctrl: 2-bit saturating branch-predictor table with a single access port
// shared between fetch lookups (priority) and queued execute updates.
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid, req_pc, req_ready    lookup request handshake
//   pred_valid, pred_taken, pred_idx registered prediction, one cycle after accept
//   res_valid, res_idx, res_taken, res_ready  outcome update handshake
// Optional build macro GSHARE_EN: XOR a global outcome history into the lookup index.
module bp_table_ctrl
    import bp_pkg::*;
#(
    parameter int IDX_W     = 4,
    parameter int PC_W      = 8,
    parameter int UPD_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    input  logic [PC_W-1:0]  req_pc,
    output logic             req_ready,
    output logic             pred_valid,
    output logic             pred_taken,
    output logic [IDX_W-1:0] pred_idx,
    input  logic             res_valid,
    input  logic [IDX_W-1:0] res_idx,
    input  logic             res_taken,
    output logic             res_ready
);

    logic [1:0]       tbl [2**IDX_W];
    logic             full;
    logic             empty;
    logic             lookup;
    logic             push;
    logic [IDX_W-1:0] idx;
    logic [IDX_W:0]   head;
    arb_state_t       state;
    logic             unused_pc;

    assign unused_pc = ^req_pc;

`ifdef GSHARE_EN
    logic [IDX_W-1:0] ghr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ghr <= '0;
        else if (push) ghr <= {ghr[IDX_W-2:0], res_taken};
    end

    assign idx = req_pc[IDX_W-1:0] ^ ghr;
`else
    assign idx = req_pc[IDX_W-1:0];
`endif

    // A full queue blocks lookups as well, so the drain is starved for at most UPD_DEPTH lookups.
    assign req_ready = !full;
    assign res_ready = !full;
    assign lookup    = req_valid && req_ready;
    assign push      = res_valid && res_ready;
    assign state     = lookup ? LOOKUP : (empty ? IDLE : DRAIN);

    bp_update_fifo #(
        .W     (IDX_W + 1),
        .DEPTH (UPD_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   ({res_idx, res_taken}),
        .pop   (state == DRAIN),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2**IDX_W; i++) tbl[i] <= CNT_RST;
        end else if (state == DRAIN) begin
            tbl[head[IDX_W:1]] <= sat_upd(tbl[head[IDX_W:1]], head[0]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_valid <= 1'b0;
            pred_taken <= 1'b0;
            pred_idx   <= '0;
        end else begin
            pred_valid <= lookup;
            if (lookup) begin
                pred_taken <= tbl[idx][1];
                pred_idx   <= idx;
            end
        end
    end

endmodule

// File: tb/tb_bp_table_ctrl.sv
// tb_bp_table_ctrl: directed and randomized checks of bp_table_ctrl against a queue/array model.
module tb_bp_table_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic [7:0] req_pc = '0;
    logic       req_ready;
    logic       pred_valid;
    logic       pred_taken;
    logic [3:0] pred_idx;
    logic       res_valid = 1'b0;
    logic [3:0] res_idx = '0;
    logic       res_taken = 1'b0;
    logic       res_ready;

    int errors = 0;
    int checks = 0;

    int         mcnt [16];
    logic [4:0] mq [$];
    logic [3:0] mghr;
    logic       epv, ept;
    logic [3:0] epi;

    bp_table_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_pc     (req_pc),
        .req_ready  (req_ready),
        .pred_valid (pred_valid),
        .pred_taken (pred_taken),
        .pred_idx   (pred_idx),
        .res_valid  (res_valid),
        .res_idx    (res_idx),
        .res_taken  (res_taken),
        .res_ready  (res_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        foreach (mcnt[i]) mcnt[i] = 3;
        mq.delete();
        mghr = '0;
        epv = 1'b0;
        ept = 1'b0;
        epi = '0;
    endtask

    // One clock: drive inputs, check handshake, advance model, check registered outputs.
    task automatic cycle(input logic rv, input logic [7:0] pc, input logic uv,
                         input logic [3:0] ui, input logic ut);
        logic       rdy, lk, pu;
        logic [3:0] ix;
        logic [4:0] h;
        req_valid = rv;
        req_pc    = pc;
        res_valid = uv;
        res_idx   = ui;
        res_taken = ut;
        #1;
        rdy = mq.size() < 4;
        chk("req_ready", req_ready, rdy);
        chk("res_ready", res_ready, rdy);
        lk = rv && rdy;
        pu = uv && rdy;
        ix = pc[3:0];
`ifdef GSHARE_EN
        ix = ix ^ mghr;
`endif
        epv = lk;
        if (lk) begin
            ept = mcnt[ix] >= 2;
            epi = ix;
        end else if (mq.size() > 0) begin
            h = mq.pop_front();
            mcnt[h[4:1]] = h[0] ? ((mcnt[h[4:1]] < 3) ? mcnt[h[4:1]] + 1 : 3)
                                : ((mcnt[h[4:1]] > 0) ? mcnt[h[4:1]] - 1 : 0);
        end
        if (pu) begin
            mq.push_back({ui, ut});
`ifdef GSHARE_EN
            mghr = {mghr[2:0], ut};
`endif
        end
        @(posedge clk);
        #1;
        chk("pred_valid", pred_valid, epv);
        chk("pred_taken", pred_taken, ept);
        chk("pred_idx", pred_idx, epi);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, 4'h0, 1'b0);
    endtask

    task automatic cmp_table(input string tag);
        for (int i = 0; i < 16; i++) chk(tag, dut.tbl[i], mcnt[i]);
    endtask

    initial begin
        int n;
        model_reset();
        #3;
        chk("rst_pred_valid", pred_valid, 0);
        chk("rst_pred_taken", pred_taken, 0);
        chk("rst_pred_idx", pred_idx, 0);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_res_ready", res_ready, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        cycle(1'b1, 8'h05, 1'b0, 4'h0, 1'b0);
        chk("first_taken", pred_taken, 1);
        chk("first_idx", pred_idx, 5);

        repeat (3) cycle(1'b0, 8'h00, 1'b1, 4'h5, 1'b0);
        idle(2);
        cycle(1'b1, 8'h05, 1'b0, 4'h0, 1'b0);
        chk("sat_taken", pred_taken, 0);
        chk("sat_cnt", dut.tbl[5], 0);
        cycle(1'b0, 8'h00, 1'b1, 4'h5, 1'b0);
        idle(1);
        chk("sat_floor", dut.tbl[5], 0);

        cycle(1'b1, 8'h03, 1'b1, 4'h3, 1'b0);
        chk("nofwd_taken", pred_taken, 1);
        idle(1);
        chk("nofwd_cnt", dut.tbl[3], 2);
        cycle(1'b0, 8'h00, 1'b1, 4'h3, 1'b0);
        idle(1);
        cycle(1'b1, 8'h03, 1'b0, 4'h0, 1'b0);
        chk("second_taken", pred_taken, 0);

        n = 0;
        for (int c = 0; c < 8; c++) begin
            if (c == 4) begin
                #1;
                chk("stall_res_ready", res_ready, 0);
                chk("stall_req_ready", req_ready, 0);
            end
            if (mq.size() < 4 && n < 5) n++;
            cycle(1'b1, 8'($urandom), n < 5 || (mq.size() < 4 && n == 4),
                  4'($urandom), 1'($urandom));
        end
        chk("all_pushed", n, 5);
        idle(6);
        cmp_table("stream_tbl");

        for (int c = 0; c < 300; c++)
            cycle($urandom_range(0, 2) != 0, 8'($urandom), $urandom_range(0, 1) == 1,
                  4'($urandom), 1'($urandom));
        idle(6);
        cmp_table("rand_tbl");

        repeat (3) cycle(1'b1, 8'($urandom), 1'b1, 4'($urandom), 1'b0);
        chk("inflight_pv", pred_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_pv", pred_valid, 0);
        chk("mid_rst_idx", pred_idx, 0);
        chk("mid_rst_req_ready", req_ready, 1);
        chk("mid_rst_empty", dut.u_fifo.empty, 1);
        model_reset();
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 8'(i), 1'b0, 4'h0, 1'b0);
            chk("post_rst_taken", pred_taken, 1);
        end

`ifdef GSHARE_EN
        rst_n = 1'b0;
        #1;
        model_reset();
        rst_n = 1'b1;
        cycle(1'b0, 8'h00, 1'b1, 4'h0, 1'b1);
        cycle(1'b0, 8'h00, 1'b1, 4'h0, 1'b1);
        cycle(1'b0, 8'h00, 1'b1, 4'h0, 1'b0);
        chk("ghr", dut.ghr, 4'b0110);
        cycle(1'b1, 8'h0F, 1'b0, 4'h0, 1'b0);
        chk("gshare_idx", pred_idx, 4'b1001);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bp_table_ctrl.md
# bp_table_ctrl

Sequencer and arbiter for a table of 2-bit saturating branch-predictor counters. It accepts prediction lookups from fetch and outcome updates from execute, and shares the table's single access port between them. Updates wait in a small queue and drain on cycles with no lookup. It replaces per-branch predictor instances with one indexed, centrally scheduled table.

## Interface
- IDX_W, 4: table index width; the table holds 2^IDX_W counters.
- PC_W, 8: width of the incoming branch PC; PC_W >= IDX_W.
- UPD_DEPTH, 4: update queue depth; must be a power of 2 and >= 2.

- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  lookup request.
- req_pc  in  PC_W  branch PC for the lookup.
- req_ready  out  1  lookup accepted this cycle when high together with req_valid.
- pred_valid  out  1  one-cycle pulse: a prediction is available.
- pred_taken  out  1  the prediction; 1 means taken.
- pred_idx  out  IDX_W  table index used; execute returns it with the outcome.
- res_valid  in  1  resolved branch outcome.
- res_idx  in  IDX_W  index from the matching pred_idx.
- res_taken  in  1  actual outcome.
- res_ready  out  1  high when the update queue is not full.

## Operation
- Table: 2^IDX_W entries of 2 bits, and every entry resets to 2'b11.
- Prediction value: taken when the counter is >= 2'b10.
- Index: req_pc[IDX_W-1:0]. With GSHARE_EN defined, the index is req_pc[IDX_W-1:0] ^ ghr.
- Lookup accept: req_valid && req_ready.
  - req_ready = !(queue full), so a full queue blocks lookups until it drains one entry.
- Update accept: res_valid && res_ready; the pair {res_idx, res_taken} is pushed to the queue.
- Port arbitration, one table access per cycle:
  - An accepted lookup wins the port.
  - Otherwise, if the queue is non-empty, the head entry is popped and written to the table.
- Counter update arithmetic, saturating at both ends:
  - taken: counter+1, holding at 2'b11.
  - not taken: counter-1, holding at 2'b00.
- No forwarding: a lookup sees only the counters already written. Queued updates to the same index are not visible until they drain.
- Simultaneous push and pop in one cycle is allowed:
  - Occupancy is unchanged.
  - On a full queue, push is blocked by res_ready even if a pop also occurs.
- Arbiter states:
  - IDLE: queue empty, no lookup.
  - LOOKUP: a lookup is accepted.
  - DRAIN: a pop is performed.
- Transitions are re-evaluated every cycle with priority LOOKUP > DRAIN > IDLE.

## Timing
- Reset values: req_ready=1, res_ready=1, pred_valid=0, pred_taken=0, pred_idx=0, queue empty, all counters 2'b11, ghr=0.
- Lookup latency: pred_valid, pred_taken and pred_idx are registered and appear the cycle after acceptance. Back-to-back lookups give one prediction per cycle.
- pred_taken and pred_idx hold their value between pulses.
- Update latency:
  - Minimum 2 cycles from acceptance to counter change: push in cycle N, pop and write in cycle N+1.
  - A lookup in N+2 sees the new value.
  - Each cycle with a lookup adds one cycle of delay.
- Starvation bound: a continuous lookup stream stalls the drain only until the queue fills. req_ready then drops, so at most UPD_DEPTH lookups get ahead of the oldest queued update.
- Reset asserted mid-operation:
  - Clears the queue, table, ghr and outputs immediately.
  - In-flight predictions and queued updates are discarded.
  - The first accept is possible on the first rising edge after rst_n deasserts.

## Configuration
- GSHARE_EN defined:
  - An IDX_W-bit global history register, ghr, is added.
  - On every accepted update, ghr <= {ghr[IDX_W-2:0], res_taken}.
  - Lookup index is pc ^ ghr, sampled at acceptance.
  - Update writes use res_idx unchanged.
- GSHARE_EN undefined: there is no ghr, and the index is the low PC bits.
- Ports are identical in both builds.

## Structure
- Shared package bp_pkg holds:
  - the counter state constants: SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11;
  - the counter reset value ST;
  - the arbiter-state enum;
  - a saturating-update function.
- Sub-module bp_update_fifo: the parameterised UPD_DEPTH queue of {idx, taken}, with push/pop, full/empty and asynchronous active-low reset.

## Test plan
- Reset, then lookup pc=0x05 -> one cycle later pred_valid=1, pred_taken=1, pred_idx=5.
- Three accepted updates, idx=5 taken=0, with no lookups; then lookup pc=0x05 -> pred_taken=0 and counter at 2'b00. A fourth not-taken update keeps the counter at 2'b00.
- Update idx=3 taken=0 pushed in the same cycle as lookup pc=0x03 -> prediction is taken (no forwarding). Two cycles later the counter is 2'b10; after a second not-taken update, a new lookup returns 0.
- Continuous lookups with 5 updates offered:
  - res_ready drops after 4 pushes (UPD_DEPTH=4) and req_ready drops with it.
  - One drain occurs, then req_ready reasserts.
  - No update is lost, checked against a reference model.
- rst_n pulsed low with 3 queued updates and a prediction in flight -> pred_valid=0 immediately, queue empty, and all lookups afterwards predict taken.
- GSHARE_EN build: updates taken, taken, not-taken give ghr=4'b0110. Lookup pc=0x0F -> pred_idx=4'b1001.
